// File: rtl/video_rx_monitor.sv
// ---------------------------------------------------------------------------
// video_rx_monitor
// Watches a parallel RGB video output and checks its geometry. It forwards
// each active pixel, checksums each frame, and flags sync and geometry
// errors.
//
// Ports
//   clk            video pixel clock, rising edge
//   reset          asynchronous active-high reset
//   video_RGB_OUT  pixel {R,G,B}
//   video_HD       horizontal sync, active-low
//   video_VD       vertical sync, active-low
//   video_DEN      data enable, active-high
//   err_clr        one-cycle pulse clearing the sticky error flags
//   pix_data       captured pixel
//   pix_valid      pix_data is valid this cycle
//   pix_sof        first forwarded pixel of a frame
//   pix_eol        last forwarded pixel of a line
//   frame_done     one-cycle pulse when a frame closes
//   frame_ok       last closed frame had exact geometry and no sync error
//   frame_sum      16-bit R+G+B checksum of the last closed frame
//   line_count     lines counted in the last closed frame (saturating)
//   locked         last closed frame was good
//   err_hlen/err_vlen/err_sync  sticky error flags
// ---------------------------------------------------------------------------
module video_rx_monitor #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] video_RGB_OUT,
  input  logic        video_HD,
  input  logic        video_VD,
  input  logic        video_DEN,
  input  logic        err_clr,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] frame_sum,
  output logic [9:0]  line_count,
  output logic        locked,
  output logic        err_hlen,
  output logic        err_vlen,
  output logic        err_sync
);

  localparam logic [9:0] H_LEN  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_LEN  = 10'(V_ACTIVE);

  typedef enum logic {ST_SEEK = 1'b0, ST_FRAME = 1'b1} state_e;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'd1023) ? v : v + 10'd1;
  endfunction

  function automatic logic [15:0] rgb_sum(input logic [23:0] p);
    return {8'd0, p[23:16]} + {8'd0, p[15:8]} + {8'd0, p[7:0]};
  endfunction

  logic [23:0] rgb_q;
  logic        hd_q, vd_q, den_q, clr_q, vd_prev_q, den_prev_q;
  logic        frame_start_s, line_end_s, sync_bad_s;
  state_e      state_q, state_d;

  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [15:0] sum_q, sum_d;
  logic        bad_q, bad_d, sof_pend_q, sof_pend_d;
  logic [23:0] pix_data_q, pix_data_d;
  logic        pix_valid_q, pix_valid_d, pix_sof_q, pix_sof_d, pix_eol_q, pix_eol_d;
  logic        frame_done_q, frame_done_d, frame_ok_q, frame_ok_d;
  logic [15:0] frame_sum_q, frame_sum_d;
  logic [9:0]  line_count_q, line_count_d;
  logic        locked_q, locked_d;
  logic        err_hlen_q, err_hlen_d, err_vlen_q, err_vlen_d, err_sync_q, err_sync_d;

  // Input capture stage. Syncs idle high so that a VD held low at release reads as a frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q      <= 24'd0;
      hd_q       <= 1'b1;
      vd_q       <= 1'b1;
      den_q      <= 1'b0;
      clr_q      <= 1'b0;
      vd_prev_q  <= 1'b1;
      den_prev_q <= 1'b0;
    end else begin
      rgb_q      <= video_RGB_OUT;
      hd_q       <= video_HD;
      vd_q       <= video_VD;
      den_q      <= video_DEN;
      clr_q      <= err_clr;
      vd_prev_q  <= vd_q;
      den_prev_q <= den_q;
    end
  end

  assign frame_start_s = vd_prev_q & ~vd_q;
  assign line_end_s    = den_prev_q & ~den_q;
  assign sync_bad_s    = den_q & (~vd_q | ~hd_q);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SEEK;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave SEEK on the first frame start, then stay aligned
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEEK: begin
        if (frame_start_s) state_d = ST_FRAME;
        else               state_d = ST_SEEK;
      end
      ST_FRAME: state_d = ST_FRAME;
      default:  state_d = ST_SEEK;
    endcase
  end

  // Output and counter logic. Within one cycle the order is: close the line,
  // then close the frame, then accept or reject the pixel.
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    sum_d        = sum_q;
    bad_d        = bad_q;
    sof_pend_d   = sof_pend_q;
    pix_data_d   = pix_data_q;
    pix_valid_d  = 1'b0;
    pix_sof_d    = 1'b0;
    pix_eol_d    = 1'b0;
    frame_done_d = 1'b0;
    frame_ok_d   = frame_ok_q;
    frame_sum_d  = frame_sum_q;
    line_count_d = line_count_q;
    locked_d     = locked_q;
    // A new error in the same cycle as a clear overrides the clear
    err_hlen_d   = err_hlen_q & ~clr_q;
    err_vlen_d   = err_vlen_q & ~clr_q;
    err_sync_d   = err_sync_q & ~clr_q;
    if (state_q == ST_FRAME) begin
      if (line_end_s) begin
        err_hlen_d = err_hlen_d | (x_d != H_LEN);
        bad_d      = bad_d | (x_d != H_LEN);
        y_d        = sat_inc10(y_d);
        x_d        = 10'd0;
      end else begin
        x_d = x_d;
      end
      if (frame_start_s) begin
        frame_done_d = 1'b1;
        line_count_d = y_d;
        frame_sum_d  = sum_d;
        frame_ok_d   = (y_d == V_LEN) & ~bad_d;
        locked_d     = (y_d == V_LEN) & ~bad_d;
        err_vlen_d   = err_vlen_d | (y_d != V_LEN);
        x_d          = 10'd0;
        y_d          = 10'd0;
        sum_d        = 16'd0;
        bad_d        = 1'b0;
        sof_pend_d   = 1'b1;
      end else begin
        sof_pend_d = sof_pend_d;
      end
      if (den_q) begin
        if (sync_bad_s) begin
          err_sync_d = 1'b1;
          bad_d      = 1'b1;
        end else begin
          pix_valid_d = 1'b1;
          pix_data_d  = rgb_q;
          pix_sof_d   = sof_pend_d;
          pix_eol_d   = (x_d == H_LAST);
          sof_pend_d  = 1'b0;
          x_d         = sat_inc10(x_d);
          sum_d       = sum_d + rgb_sum(rgb_q);
        end
      end else begin
        pix_valid_d = 1'b0;
      end
    end else begin
      // Counters stay at zero while seeking
      sof_pend_d = frame_start_s;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q          <= 10'd0;
      y_q          <= 10'd0;
      sum_q        <= 16'd0;
      bad_q        <= 1'b0;
      sof_pend_q   <= 1'b0;
      pix_data_q   <= 24'd0;
      pix_valid_q  <= 1'b0;
      pix_sof_q    <= 1'b0;
      pix_eol_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_sum_q  <= 16'd0;
      line_count_q <= 10'd0;
      locked_q     <= 1'b0;
      err_hlen_q   <= 1'b0;
      err_vlen_q   <= 1'b0;
      err_sync_q   <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      sum_q        <= sum_d;
      bad_q        <= bad_d;
      sof_pend_q   <= sof_pend_d;
      pix_data_q   <= pix_data_d;
      pix_valid_q  <= pix_valid_d;
      pix_sof_q    <= pix_sof_d;
      pix_eol_q    <= pix_eol_d;
      frame_done_q <= frame_done_d;
      frame_ok_q   <= frame_ok_d;
      frame_sum_q  <= frame_sum_d;
      line_count_q <= line_count_d;
      locked_q     <= locked_d;
      err_hlen_q   <= err_hlen_d;
      err_vlen_q   <= err_vlen_d;
      err_sync_q   <= err_sync_d;
    end
  end

  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;
  assign pix_sof    = pix_sof_q;
  assign pix_eol    = pix_eol_q;
  assign frame_done = frame_done_q;
  assign frame_ok   = frame_ok_q;
  assign frame_sum  = frame_sum_q;
  assign line_count = line_count_q;
  assign locked     = locked_q;
  assign err_hlen   = err_hlen_q;
  assign err_vlen   = err_vlen_q;
  assign err_sync   = err_sync_q;

endmodule

// File: tb/tb_video_rx_monitor.sv
// ---------------------------------------------------------------------------
// tb_video_rx_monitor
// Directed frame sequence with random pixel values and blanking. The bench
// keeps a frame-level model of the input: each run of DEN is one line, and
// its length is the count of pixels accepted while both syncs are high. The
// model also holds a queue of the pixels expected on the output.
// ---------------------------------------------------------------------------
module tb_video_rx_monitor;

  localparam int H = 12;
  localparam int V = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] video_RGB_OUT;
  logic        video_HD, video_VD, video_DEN, err_clr;
  logic [23:0] pix_data;
  logic        pix_valid, pix_sof, pix_eol, frame_done, frame_ok, locked;
  logic [15:0] frame_sum;
  logic [9:0]  line_count;
  logic        err_hlen, err_vlen, err_sync;

  video_rx_monitor #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .clk(clk), .reset(reset), .video_RGB_OUT(video_RGB_OUT),
    .video_HD(video_HD), .video_VD(video_VD), .video_DEN(video_DEN),
    .err_clr(err_clr), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done),
    .frame_ok(frame_ok), .frame_sum(frame_sum), .line_count(line_count),
    .locked(locked), .err_hlen(err_hlen), .err_vlen(err_vlen), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model state
  bit          in_frame = 1'b0, m_sof = 1'b0, m_in_run = 1'b0, m_bad = 1'b0;
  int          m_run_good = 0, m_lines = 0;
  logic [15:0] m_sum = 16'd0;
  bit          exp_hlen = 1'b0, exp_vlen = 1'b0, exp_sync = 1'b0, exp_locked = 1'b0;
  bit          exp_ok = 1'b0, closed_now = 1'b0, prev_vd = 1'b1, drv_good = 1'b0;
  logic [15:0] exp_sum = 16'd0;
  int          exp_lines = 0, exp_fd = 0;
  logic [25:0] pq[$];

  // Monitor captures
  int          fd_count = 0;
  logic        cap_ok = 1'b0, cap_locked = 1'b0;
  logic [15:0] cap_sum = 16'd0;
  logic [9:0]  cap_lines = 10'd0;
  logic        a1 = 1'b0, a2 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] rnd();
    return 24'($urandom);
  endfunction

  // Delay the "pixel expected" flag to the output's two-cycle latency
  always @(posedge clk) begin
    if (reset) begin
      a1 <= 1'b0;
      a2 <= 1'b0;
    end else begin
      a1 <= drv_good;
      a2 <= a1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("pix_valid", pix_valid, a2);
      if (pix_valid) begin
        chk("pix_avail", pq.size() > 0, 1);
        if (pq.size() > 0) chk("pix_word", {pix_sof, pix_eol, pix_data}, pq.pop_front());
      end
      if (frame_done) begin
        fd_count++;
        cap_ok     = frame_ok;
        cap_sum    = frame_sum;
        cap_lines  = line_count;
        cap_locked = locked;
      end
    end
  end

  // One pin cycle; the model applies the same order of events as the input rules
  task automatic cyc(input logic [23:0] rgb, input logic hd, input logic vd,
                     input logic den, input logic clr);
    if (clr) begin exp_hlen = 0; exp_vlen = 0; exp_sync = 0; end
    if (!den && m_in_run) begin
      m_in_run = 0;
      if (in_frame) begin
        m_lines++;
        if (m_run_good != H) begin m_bad = 1; exp_hlen = 1; end
      end
      m_run_good = 0;
    end
    if (!vd && prev_vd) begin
      if (in_frame) begin
        exp_lines  = (m_lines > 1023) ? 1023 : m_lines;
        exp_ok     = (m_lines == V) && !m_bad;
        exp_sum    = m_sum;
        exp_locked = exp_ok;
        if (m_lines != V) exp_vlen = 1;
        exp_fd++;
        closed_now = 1;
      end
      in_frame = 1; m_lines = 0; m_bad = 0; m_sum = 16'd0; m_run_good = 0; m_sof = 1;
    end
    drv_good = 0;
    if (den) begin
      m_in_run = 1;
      if (in_frame) begin
        if (vd && hd) begin
          pq.push_back({m_sof, (m_run_good == H - 1), rgb});
          m_sof = 0;
          m_run_good++;
          m_sum = m_sum + 16'(rgb[23:16]) + 16'(rgb[15:8]) + 16'(rgb[7:0]);
          drv_good = 1;
        end else begin
          m_bad = 1;
          exp_sync = 1;
        end
      end
    end
    prev_vd = vd;
    video_RGB_OUT = rgb; video_HD = hd; video_VD = vd; video_DEN = den; err_clr = clr;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(rnd(), 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_close();
    chk("fd_count", fd_count, exp_fd);
    if (closed_now) begin
      chk("cap_ok", cap_ok, exp_ok);
      chk("cap_sum", cap_sum, exp_sum);
      chk("cap_lines", cap_lines, exp_lines);
      chk("cap_locked", cap_locked, exp_locked);
    end
    closed_now = 0;
    chk("frame_ok", frame_ok, exp_ok);
    chk("frame_sum", frame_sum, exp_sum);
    chk("line_count", line_count, exp_lines);
    chk("locked", locked, exp_locked);
    chk("err_flags", {err_hlen, err_vlen, err_sync}, {exp_hlen, exp_vlen, exp_sync});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("reset_outs", {pix_data, pix_valid, pix_sof, pix_eol, frame_done, frame_ok,
                       frame_sum, line_count, locked, err_hlen, err_vlen, err_sync}, 64'd0);
    in_frame = 0; m_sof = 0; m_in_run = 0; m_bad = 0; m_run_good = 0; m_lines = 0;
    m_sum = 16'd0; exp_hlen = 0; exp_vlen = 0; exp_sync = 0; exp_locked = 0;
    exp_ok = 0; exp_sum = 16'd0; exp_lines = 0; closed_now = 0; prev_vd = 1; drv_good = 0;
    pq.delete();
    video_HD = 1'b1; video_VD = 1'b1; video_DEN = 1'b0; err_clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    chk("fd_after_rst", fd_count, exp_fd);
  endtask

  // Frame start (VD low 3 cycles), close checks, then nlines lines of H pixels
  task automatic send_frame(input int nlines, input int short_idx, input int sync_pre,
                            input bit clr_first, input int rst_line, input bit const_pix);
    int len;
    for (int i = 0; i < 3; i++)
      cyc(rnd(), 1'b1, 1'b0, (i < sync_pre), (clr_first && (i == 0)));
    idle(2);
    check_close();
    idle(int'($urandom_range(0, 2)));
    for (int l = 0; l < nlines; l++) begin
      cyc(rnd(), 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(rnd(), 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(rnd(), 1'b1, 1'b1, 1'b0, 1'b0);
      len = (l == short_idx) ? H - 1 : H;
      for (int p = 0; p < len; p++) begin
        if (l == rst_line && p == 3) begin
          do_reset();
          return;
        end
        cyc(const_pix ? 24'h010203 : rnd(), 1'b1, 1'b1, 1'b1, 1'b0);
      end
      idle(int'($urandom_range(1, 2)));
    end
    idle(2);
  endtask

  initial begin
    reset = 1'b1;
    video_RGB_OUT = 24'd0; video_HD = 1'b1; video_VD = 1'b1; video_DEN = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {pix_data, pix_valid, pix_sof, pix_eol, frame_done, frame_ok,
                       frame_sum, line_count, locked, err_hlen, err_vlen, err_sync}, 64'd0);
    reset = 1'b0;

    // DEN activity before any frame start must not be forwarded
    for (int p = 0; p < H; p++) cyc(rnd(), 1'b1, 1'b1, 1'b1, 1'b0);
    idle(3);

    send_frame(V, -1, 0, 1'b0, -1, 1'b0);       // F1: leaves SEEK, no frame_done
    send_frame(V, -1, 0, 1'b0, -1, 1'b0);       // F2: closes F1 good
    send_frame(V, -1, 0, 1'b0, -1, 1'b1);       // F3: constant pixels
    send_frame(V, 2, 0, 1'b0, -1, 1'b0);        // F4: closes F3, one short line inside
    chk("const_sum", frame_sum, (H * V * 6) % 65536);
    send_frame(V, -1, 0, 1'b0, -1, 1'b0);       // F5: closes F4 with err_hlen
    cyc(rnd(), 1'b1, 1'b1, 1'b0, 1'b1);
    idle(2);
    chk("clr_flags", {err_hlen, err_vlen, err_sync}, {exp_hlen, exp_vlen, exp_sync});
    send_frame(V - 1, -1, 0, 1'b0, -1, 1'b0);   // F6: closes F5, one line short
    send_frame(V, -1, 2, 1'b1, -1, 1'b0);       // F7: DEN through VD fall, clear collides
    send_frame(V, -1, 0, 1'b0, 1, 1'b0);        // F8: closes F7 bad, reset mid-line
    idle(3);
    send_frame(V, -1, 0, 1'b0, -1, 1'b0);       // F9: back from SEEK, no frame_done
    send_frame(V, -1, 0, 1'b0, -1, 1'b0);       // F10: closes F9
    send_frame(0, -1, 0, 1'b0, -1, 1'b0);       // closes F10
    idle(3);
    chk("pix_drained", pq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
